// File: rtl/cv32e40s_pkg.sv
// Shared constants and types for the OBI arbiter slice.
// Requester IDs double as the mux select and the ID FIFO payload.
package cv32e40s_pkg;

  localparam logic OBI_ARB_M0 = 1'b0;
  localparam logic OBI_ARB_M1 = 1'b1;

  typedef enum logic {
    ArbIdle,
    ArbLocked
  } obi_arb_state_e;

endpackage

// File: rtl/cv32e40s_obi_arb_id_fifo.sv
// In-order FIFO of requester IDs for accepted, not yet answered OBI transactions.
// Push while full and pop while empty are ignored.
module cv32e40s_obi_arb_id_fifo #(
  parameter int unsigned DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push_i,
  input  logic pop_i,
  input  logic id_i,
  output logic head_o,
  output logic empty_o,
  output logic full_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] mem_q;
  logic [PtrW-1:0]  rd_ptr_q;
  logic [PtrW-1:0]  wr_ptr_q;
  logic [CntW-1:0]  cnt_q;
  logic             push_en;
  logic             pop_en;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
    return (ptr == PtrW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CntW'(DEPTH));
  assign head_o  = mem_q[rd_ptr_q];
  assign push_en = push_i && !full_o;
  assign pop_en  = pop_i && !empty_o;

  always_ff @(posedge clk) begin
    if (push_en) begin
      mem_q[wr_ptr_q] <= id_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_en) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop_en)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (push_en && !pop_en) begin
        cnt_q <= cnt_q + 1'b1;
      end else if (pop_en && !push_en) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/cv32e40s_obi_arbiter.sv
// Two-requester OBI arbiter: round-robin on ties, selection held until granted,
// responses routed back in order through an ID FIFO.
module cv32e40s_obi_arbiter
  import cv32e40s_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING   = 2,
  parameter int unsigned OUTSTND_CNT_WIDTH = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         m0_req_i,
  input  logic [31:0]                  m0_addr_i,
  input  logic                         m0_we_i,
  input  logic [3:0]                   m0_be_i,
  input  logic [31:0]                  m0_wdata_i,
  input  logic                         m1_req_i,
  input  logic [31:0]                  m1_addr_i,
  input  logic                         m1_we_i,
  input  logic [3:0]                   m1_be_i,
  input  logic [31:0]                  m1_wdata_i,
  output logic                         m0_gnt_o,
  output logic                         m1_gnt_o,
  output logic                         m0_rvalid_o,
  output logic                         m1_rvalid_o,
  output logic                         obi_req_o,
  output logic [31:0]                  obi_addr_o,
  output logic                         obi_we_o,
  output logic [3:0]                   obi_be_o,
  output logic [31:0]                  obi_wdata_o,
  input  logic                         obi_gnt_i,
  input  logic                         obi_rvalid_i,
  output logic [OUTSTND_CNT_WIDTH-1:0] bus_cnt_o,
  output logic                         protocol_err_o
);

  obi_arb_state_e               state_q, state_d;
  logic                         sel_q, sel_d;
  logic                         last_q, last_d;
  logic [OUTSTND_CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                         sel;
  logic                         not_full;
  logic                         accept;
  logic                         rsp_valid;
  logic                         fifo_head;
  logic                         fifo_empty;
  logic                         fifo_full;

  // A locked selection must not change until the bus grants it.
  always_comb begin
    sel = sel_q;
    if (state_q == ArbIdle) begin
      if (m0_req_i && m1_req_i) begin
        sel = ~last_q;
      end else if (m1_req_i) begin
        sel = OBI_ARB_M1;
      end else begin
        sel = OBI_ARB_M0;
      end
    end
  end

  assign not_full    = (cnt_q != OUTSTND_CNT_WIDTH'(MAX_OUTSTANDING));
  assign obi_req_o   = ((sel == OBI_ARB_M1) ? m1_req_i : m0_req_i) && not_full;
  assign obi_addr_o  = (sel == OBI_ARB_M1) ? m1_addr_i  : m0_addr_i;
  assign obi_we_o    = (sel == OBI_ARB_M1) ? m1_we_i    : m0_we_i;
  assign obi_be_o    = (sel == OBI_ARB_M1) ? m1_be_i    : m0_be_i;
  assign obi_wdata_o = (sel == OBI_ARB_M1) ? m1_wdata_i : m0_wdata_i;

  assign accept   = obi_req_o && obi_gnt_i;
  assign m0_gnt_o = accept && (sel == OBI_ARB_M0);
  assign m1_gnt_o = accept && (sel == OBI_ARB_M1);

  assign rsp_valid      = obi_rvalid_i && (cnt_q != '0);
  assign protocol_err_o = obi_rvalid_i && (cnt_q == '0);
  assign m0_rvalid_o    = rsp_valid && (fifo_head == OBI_ARB_M0);
  assign m1_rvalid_o    = rsp_valid && (fifo_head == OBI_ARB_M1);
  assign bus_cnt_o      = cnt_q;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ArbIdle: begin
        if (obi_req_o && !obi_gnt_i) begin
          state_d = ArbLocked;
          sel_d   = sel;
        end
      end
      ArbLocked: begin
        if (obi_gnt_i) state_d = ArbIdle;
      end
    endcase
    if (accept) last_d = sel;
    if (accept && !rsp_valid) begin
      cnt_d = cnt_q + 1'b1;
    end else if (rsp_valid && !accept) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ArbIdle;
      sel_q   <= OBI_ARB_M0;
      last_q  <= OBI_ARB_M1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  cv32e40s_obi_arb_id_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (accept),
    .pop_i   (rsp_valid),
    .id_i    (sel),
    .head_o  (fifo_head),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  // The counter and the FIFO occupancy track the same transactions.
  fifo_empty_matches_cnt: assert property (@(posedge clk) disable iff (!rst_n)
    fifo_empty == (cnt_q == '0));
  fifo_full_matches_cnt: assert property (@(posedge clk) disable iff (!rst_n)
    fifo_full == (cnt_q == OUTSTND_CNT_WIDTH'(MAX_OUTSTANDING)));

endmodule

// File: tb/tb_cv32e40s_obi_arbiter.sv
// Bench for cv32e40s_obi_arbiter: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a queue-based model.
module tb_cv32e40s_obi_arbiter;

  localparam int unsigned MAX = 2;
  localparam int unsigned CW  = $clog2(MAX + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          m0_req = 1'b0, m1_req = 1'b0;
  logic [31:0]   m0_addr = '0, m1_addr = '0, m0_wdata = '0, m1_wdata = '0;
  logic          m0_we = 1'b0, m1_we = 1'b0;
  logic [3:0]    m0_be = '0, m1_be = '0;
  logic          obi_gnt = 1'b0, obi_rvalid = 1'b0;
  logic          m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o;
  logic          obi_req_o, obi_we_o, protocol_err_o;
  logic [31:0]   obi_addr_o, obi_wdata_o;
  logic [3:0]    obi_be_o;
  logic [CW-1:0] bus_cnt_o;

  int checks = 0;
  int errors = 0;

  // Model: in-order queue of requester IDs awaiting a response.
  bit q[$];
  bit locked = 1'b0, msel = 1'b0, last = 1'b1, model_ok = 1'b0;
  bit pend0 = 1'b0, pend1 = 1'b0;

  always #5 clk = ~clk;

  cv32e40s_obi_arbiter #(
    .MAX_OUTSTANDING (MAX)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .m0_req_i       (m0_req),
    .m0_addr_i      (m0_addr),
    .m0_we_i        (m0_we),
    .m0_be_i        (m0_be),
    .m0_wdata_i     (m0_wdata),
    .m1_req_i       (m1_req),
    .m1_addr_i      (m1_addr),
    .m1_we_i        (m1_we),
    .m1_be_i        (m1_be),
    .m1_wdata_i     (m1_wdata),
    .m0_gnt_o       (m0_gnt_o),
    .m1_gnt_o       (m1_gnt_o),
    .m0_rvalid_o    (m0_rvalid_o),
    .m1_rvalid_o    (m1_rvalid_o),
    .obi_req_o      (obi_req_o),
    .obi_addr_o     (obi_addr_o),
    .obi_we_o       (obi_we_o),
    .obi_be_o       (obi_be_o),
    .obi_wdata_o    (obi_wdata_o),
    .obi_gnt_i      (obi_gnt),
    .obi_rvalid_i   (obi_rvalid),
    .bus_cnt_o      (bus_cnt_o),
    .protocol_err_o (protocol_err_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic bit exp_sel();
    if (locked) return msel;
    if (m0_req && m1_req) return !last;
    return m1_req;
  endfunction

  function automatic bit exp_req();
    return (exp_sel() ? m1_req : m0_req) && (q.size() != MAX);
  endfunction

  // Model state update.
  initial forever begin
    @(posedge clk);
    if (!rst_n) begin
      q.delete();
      locked = 1'b0;
      msel = 1'b0;
      last = 1'b1;
      pend0 = 1'b0;
      pend1 = 1'b0;
      model_ok = 1'b1;
    end else if (model_ok) begin
      bit s, r, acc;
      s = exp_sel();
      r = exp_req();
      acc = r && obi_gnt;
      pend0 = m0_req && !(acc && !s);
      pend1 = m1_req && !(acc && s);
      if (obi_rvalid && q.size() > 0) void'(q.pop_front());
      if (acc) begin
        q.push_back(s);
        last = s;
      end
      if (!locked && r && !obi_gnt) begin
        locked = 1'b1;
        msel = s;
      end else if (locked && obi_gnt) begin
        locked = 1'b0;
      end
    end
  end

  // Per-cycle comparison against the model, mid low phase.
  initial forever begin
    @(negedge clk);
    #1;
    if (model_ok) begin
      bit s, r, hv;
      s = exp_sel();
      r = exp_req();
      hv = obi_rvalid && (q.size() > 0);
      chk("obi_req", obi_req_o, r);
      chk("m0_gnt", m0_gnt_o, r && obi_gnt && !s);
      chk("m1_gnt", m1_gnt_o, r && obi_gnt && s);
      chk("obi_addr", obi_addr_o, s ? m1_addr : m0_addr);
      chk("obi_we", obi_we_o, s ? m1_we : m0_we);
      chk("obi_be", obi_be_o, s ? m1_be : m0_be);
      chk("obi_wdata", obi_wdata_o, s ? m1_wdata : m0_wdata);
      chk("bus_cnt", bus_cnt_o, q.size());
      chk("m0_rvalid", m0_rvalid_o, hv && (q[0] == 1'b0));
      chk("m1_rvalid", m1_rvalid_o, hv && (q[0] == 1'b1));
      chk("protocol_err", protocol_err_o, obi_rvalid && (q.size() == 0));
    end
  end

  task automatic cyc(input bit r0, input bit r1, input bit g, input bit rv);
    @(negedge clk);
    m0_req = r0;
    m1_req = r1;
    obi_gnt = g;
    obi_rvalid = rv;
    m0_addr = $urandom;
    m1_addr = $urandom;
    m0_wdata = $urandom;
    m1_wdata = $urandom;
    m0_we = 1'($urandom_range(0, 1));
    m1_we = 1'($urandom_range(0, 1));
    m0_be = 4'($urandom_range(0, 15));
    m1_be = 4'($urandom_range(0, 15));
    #2;
  endtask

  initial begin
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    rst_n = 1'b1;
    chk("rst_cnt", bus_cnt_o, 0);
    chk("rst_req", obi_req_o, 0);
    chk("rst_perr", protocol_err_o, 0);

    // Continuous tie with bus always granting: m0, m1, m0, m1.
    cyc(1, 1, 1, 0); chk("rr_gnt1", {m1_gnt_o, m0_gnt_o}, 2'b01);
    cyc(1, 1, 1, 1); chk("rr_gnt2", {m1_gnt_o, m0_gnt_o}, 2'b10);
    cyc(1, 1, 1, 1); chk("rr_gnt3", {m1_gnt_o, m0_gnt_o}, 2'b01);
    cyc(1, 1, 1, 1); chk("rr_gnt4", {m1_gnt_o, m0_gnt_o}, 2'b10);
    chk("rr_cnt", bus_cnt_o, 1);
    cyc(0, 0, 0, 1); chk("rr_rv", {m1_rvalid_o, m0_rvalid_o}, 2'b10);
    cyc(0, 0, 0, 0); chk("rr_drain", bus_cnt_o, 0);

    // Locked m0 survives m1 arriving.
    cyc(1, 0, 0, 0); chk("lock_req", obi_req_o, 1); chk("lock_g0", m0_gnt_o, 0);
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(1, 1, 1, 0); chk("lock_gnt", {m1_gnt_o, m0_gnt_o}, 2'b01);
    chk("lock_addr", obi_addr_o, m0_addr);
    cyc(0, 1, 1, 0); chk("lock_next", {m1_gnt_o, m0_gnt_o}, 2'b10);
    cyc(0, 0, 0, 1); chk("lock_rv0", {m1_rvalid_o, m0_rvalid_o}, 2'b01);
    chk("lock_cnt", bus_cnt_o, 2);
    cyc(0, 0, 0, 1); chk("lock_rv1", {m1_rvalid_o, m0_rvalid_o}, 2'b10);
    cyc(0, 0, 0, 0); chk("lock_drain", bus_cnt_o, 0);

    // Outstanding limit, no bypass on a same-cycle response.
    cyc(1, 0, 1, 0);
    cyc(1, 0, 1, 0);
    cyc(1, 0, 1, 0); chk("full_cnt", bus_cnt_o, 2); chk("full_req", obi_req_o, 0);
    chk("full_gnt", m0_gnt_o, 0);
    cyc(1, 0, 1, 1); chk("full_nobyp", obi_req_o, 0); chk("full_rv", m0_rvalid_o, 1);
    cyc(1, 0, 1, 0); chk("full_cnt1", bus_cnt_o, 1); chk("full_req1", obi_req_o, 1);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0); chk("full_drain", bus_cnt_o, 0);

    // Response ordering, and accept with response in the same cycle.
    cyc(0, 1, 1, 0); chk("ord_g1", m1_gnt_o, 1);
    cyc(1, 0, 1, 0); chk("ord_g0", m0_gnt_o, 1);
    cyc(0, 0, 0, 1); chk("ord_rv1", {m1_rvalid_o, m0_rvalid_o}, 2'b10);
    cyc(0, 0, 0, 1); chk("ord_rv0", {m1_rvalid_o, m0_rvalid_o}, 2'b01);
    cyc(1, 0, 1, 0);
    cyc(1, 0, 1, 1); chk("same_pre", bus_cnt_o, 1);
    cyc(0, 0, 0, 0); chk("same_post", bus_cnt_o, 1);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0); chk("same_drain", bus_cnt_o, 0);

    // Unexpected response.
    cyc(0, 0, 0, 1); chk("perr_on", protocol_err_o, 1);
    chk("perr_rv", {m1_rvalid_o, m0_rvalid_o}, 2'b00);
    cyc(0, 0, 0, 0); chk("perr_off", protocol_err_o, 0); chk("perr_cnt", bus_cnt_o, 0);

    // Reset with two outstanding; last_q was m0, reset makes m0 win again.
    cyc(1, 0, 1, 0);
    cyc(1, 0, 1, 0);
    cyc(0, 0, 0, 0); chk("mrst_pre", bus_cnt_o, 2);
    rst_n = 1'b0;
    cyc(0, 0, 0, 0);
    rst_n = 1'b1;
    chk("mrst_cnt", bus_cnt_o, 0);
    cyc(1, 1, 1, 0); chk("mrst_tie", {m1_gnt_o, m0_gnt_o}, 2'b01);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);

    // Randomized traffic; requesters hold req and payload until granted.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst_n = ($urandom_range(0, 199) != 0);
      if (!pend0) begin
        m0_req = 1'($urandom_range(0, 1));
        m0_addr = $urandom;
        m0_wdata = $urandom;
        m0_we = 1'($urandom_range(0, 1));
        m0_be = 4'($urandom_range(0, 15));
      end
      if (!pend1) begin
        m1_req = 1'($urandom_range(0, 1));
        m1_addr = $urandom;
        m1_wdata = $urandom;
        m1_we = 1'($urandom_range(0, 1));
        m1_be = 4'($urandom_range(0, 15));
      end
      obi_gnt = ($urandom_range(0, 3) != 0);
      obi_rvalid = ($urandom_range(0, 2) == 0);
    end
    rst_n = 1'b1;
    cyc(0, 0, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
